servo_pose_sequencer: RTL and testbench

- Parametrised N-channel servo pose sequencer. It drives NCH PWM servo outputs through a programmable table of up to NSTEP poses.
- Each pose holds one pulse-width target per channel. Outputs slew toward the targets at a bounded rate, and the sequencer advances only after every channel has held its target for SETTLE whole frames.
- Sits between the navigation/top-level controller (START/ABORT, table writes) and the arm servo pins. Replaces the fixed claw/joint pick-and-place sequence.

---
 rtl/servo_pose_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_servo_pose_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pose_sequencer.sv
// servo_pose_sequencer
// N-channel PWM servo pose sequencer. A table of up to NSTEP poses holds one
// pulse-width target per channel. Each frame start slews every channel toward
// its target by at most SLEW counts. A step completes once all channels have
// sat on target for SETTLE whole frames, then the next pose is loaded.
//
// Optional build macro: SERVO_SEQ_LOOP_EN adds the LOOP input. When LOOP is
// sampled high on START, completing the last step pulses DONE and wraps back
// to step 0 instead of returning to idle.
//
// Control handshake: START and ABORT are single-cycle pulses with no
// back-pressure. START is taken only while BUSY=0; ABORT acts only while
// BUSY=1 and beats a simultaneous START. WR_EN is a fire-and-forget strobe,
// taken only while BUSY=0 with in-range WR_STEP/WR_CH, otherwise dropped.
module servo_pose_sequencer #(
   parameter int NCH     = 3,
   parameter int NSTEP   = 8,
   parameter int PW_W    = 20,
   parameter int FRAME   = 2000000,
   parameter int SLEW    = 4096,
   parameter int SETTLE  = 5,
   parameter int HOME_PW = 150000,
   localparam int SW     = (NSTEP > 1) ? $clog2(NSTEP) : 1,
   localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            START,
   input  logic            ABORT,
`ifdef SERVO_SEQ_LOOP_EN
   input  logic            LOOP,
`endif
   input  logic [SW-1:0]   LAST_STEP,
   input  logic            WR_EN,
   input  logic [SW-1:0]   WR_STEP,
   input  logic [CW-1:0]   WR_CH,
   input  logic [PW_W-1:0] WR_DATA,
   output logic [NCH-1:0]  PWM,
   output logic            BUSY,
   output logic            DONE,
   output logic [SW-1:0]   STEP,
   output logic            AT_TARGET
);

   localparam int FW         = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam int MW         = (FW > PW_W) ? FW : PW_W;
   localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
   localparam int STW        = $clog2(SETTLE_EFF + 1);
   localparam logic [PW_W-1:0] SLEW_PW = PW_W'(SLEW);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVE   = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [FW-1:0]     fcnt_q;
   logic              frame_start;
   logic [PW_W-1:0]   cur_q   [NCH];
   logic [PW_W-1:0]   tgt_q   [NCH];
   logic [PW_W-1:0]   cur_tgt [NCH];
   logic [PW_W-1:0]   eff_tgt [NCH];
   logic [PW_W-1:0]   slew_nxt[NCH];
   logic [PW_W-1:0]   tbl_q   [NSTEP][NCH];
   logic [NCH-1:0]    pwm_q;
   logic [SW-1:0]     step_q, step_d;
   logic [SW-1:0]     last_q, last_d;
   logic [STW-1:0]    scnt_q, scnt_d;
   logic              done_q, done_d;
   logic              load_en;
   logic [SW-1:0]     load_idx;
   logic              abort_act;
   logic              all_at_nxt;
   logic              all_at_now;
   logic              wr_ok;
`ifdef SERVO_SEQ_LOOP_EN
   logic              loop_q, loop_d;
`endif

   // One slew step: jump to target when within SLEW, else move SLEW toward it.
   function automatic logic [PW_W-1:0] slew_step(input logic [PW_W-1:0] cur,
                                                 input logic [PW_W-1:0] tgt);
      logic [PW_W-1:0] diff;
      if (tgt >= cur) begin
         diff = tgt - cur;
         return (diff <= SLEW_PW) ? tgt : cur + SLEW_PW;
      end else begin
         diff = cur - tgt;
         return (diff <= SLEW_PW) ? tgt : cur - SLEW_PW;
      end
   endfunction

   assign frame_start = (fcnt_q == '0);
   assign abort_act   = ABORT && (state_q != S_IDLE);
   assign wr_ok       = WR_EN && (state_q == S_IDLE)
                        && (32'(WR_STEP) < NSTEP) && (32'(WR_CH) < NCH);

   // Per-channel targets: idle (or aborting) pins the target to the current
   // width so nothing moves; otherwise the loaded pose is the target.
   always_comb begin
      all_at_nxt = 1'b1;
      all_at_now = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         cur_tgt[i]  = (state_q == S_IDLE) ? cur_q[i] : tgt_q[i];
         eff_tgt[i]  = abort_act ? cur_q[i] : cur_tgt[i];
         slew_nxt[i] = slew_step(cur_q[i], eff_tgt[i]);
         if (slew_nxt[i] != tgt_q[i]) all_at_nxt = 1'b0;
         if (cur_q[i] != cur_tgt[i])  all_at_now = 1'b0;
      end
   end

   // Sequencer next-state. A step completes at the frame start that closes
   // SETTLE whole frames on target: the counter is 1 on the first at-target
   // frame start and completion fires when a further one arrives at SETTLE.
   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      last_d   = last_q;
      scnt_d   = scnt_q;
      done_d   = 1'b0;
      load_en  = 1'b0;
      load_idx = step_q;
`ifdef SERVO_SEQ_LOOP_EN
      loop_d   = loop_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (START && !ABORT) begin
               last_d   = (32'(LAST_STEP) > NSTEP - 1) ? SW'(NSTEP - 1) : LAST_STEP;
               step_d   = '0;
               load_en  = 1'b1;
               load_idx = '0;
               scnt_d   = '0;
               state_d  = S_MOVE;
`ifdef SERVO_SEQ_LOOP_EN
               loop_d   = LOOP;
`endif
            end
         end
         S_MOVE: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else if (frame_start && all_at_nxt) begin
               state_d = S_SETTLE;
               scnt_d  = STW'(1);
            end
         end
         S_SETTLE: begin
            if (ABORT) begin
               state_d = S_IDLE;
            end else if (frame_start) begin
               if (!all_at_nxt) begin
                  scnt_d  = '0;
                  state_d = S_MOVE;
               end else if (scnt_q >= STW'(SETTLE_EFF)) begin
                  scnt_d = '0;
                  if (step_q == last_q) begin
                     done_d  = 1'b1;
                     state_d = S_IDLE;
`ifdef SERVO_SEQ_LOOP_EN
                     if (loop_q) begin
                        step_d   = '0;
                        load_en  = 1'b1;
                        load_idx = '0;
                        state_d  = S_MOVE;
                     end
`endif
                  end else begin
                     step_d   = step_q + 1'b1;
                     load_en  = 1'b1;
                     load_idx = step_q + 1'b1;
                     state_d  = S_MOVE;
                  end
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state and bookkeeping registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         last_q  <= '0;
         scnt_q  <= '0;
         done_q  <= 1'b0;
`ifdef SERVO_SEQ_LOOP_EN
         loop_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         last_q  <= last_d;
         scnt_q  <= scnt_d;
         done_q  <= done_d;
`ifdef SERVO_SEQ_LOOP_EN
         loop_q  <= loop_d;
`endif
      end
   end

   // Frame counter, 0..FRAME-1.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         fcnt_q <= '0;
      end else if (fcnt_q == FW'(FRAME - 1)) begin
         fcnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_q + 1'b1;
      end
   end

   // Current widths slew once per frame; targets load on START or step advance.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NCH; i++) begin
            cur_q[i] <= PW_W'(HOME_PW);
            tgt_q[i] <= PW_W'(HOME_PW);
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (frame_start) cur_q[i] <= slew_nxt[i];
            if (load_en)     tgt_q[i] <= tbl_q[load_idx][i];
         end
      end
   end

   // Registered PWM compare, one cycle behind the frame counter.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pwm_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            pwm_q[i] <= (MW'(fcnt_q) < MW'(cur_q[i]));
         end
      end
   end

   // Pose table storage; deliberately not reset.
   always_ff @(posedge CLK) begin
      if (wr_ok) tbl_q[WR_STEP][WR_CH] <= WR_DATA;
   end

   assign PWM       = pwm_q;
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = done_q;
   assign STEP      = step_q;
   assign AT_TARGET = all_at_now;

endmodule

// File: tb/tb_servo_pose_sequencer.sv
// tb_servo_pose_sequencer
// Directed bench with a small frame model. Channel widths are measured from
// PWM high-time per frame; DONE and STEP changes are logged by frame number.
module tb_servo_pose_sequencer;

   localparam int NCH     = 3;
   localparam int NSTEP   = 8;
   localparam int PW_W    = 20;
   localparam int FRAME   = 100;
   localparam int SLEW    = 10;
   localparam int SETTLE  = 5;
   localparam int HOME_PW = 50;
   localparam int SW      = 3;
   localparam int CW      = 2;

   logic            CLK = 1'b0;
   logic            RST_N = 1'b0;
   logic            START = 1'b0;
   logic            ABORT = 1'b0;
   logic [SW-1:0]   LAST_STEP = '0;
   logic            WR_EN = 1'b0;
   logic [SW-1:0]   WR_STEP = '0;
   logic [CW-1:0]   WR_CH = '0;
   logic [PW_W-1:0] WR_DATA = '0;
   logic [NCH-1:0]  PWM;
   logic            BUSY;
   logic            DONE;
   logic [SW-1:0]   STEP;
   logic            AT_TARGET;
`ifdef SERVO_SEQ_LOOP_EN
   logic            LOOP = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int fc = 0;
   int frame_num = 0;
   int done_cnt = 0;
   int done_frame = -1;
   int done_fc = -1;
   logic [SW-1:0] step_prev = '0;
   logic [31:0]   exp_q[$];
   logic [31:0]   obs_q[$];

   servo_pose_sequencer #(
      .NCH(NCH), .NSTEP(NSTEP), .PW_W(PW_W), .FRAME(FRAME),
      .SLEW(SLEW), .SETTLE(SETTLE), .HOME_PW(HOME_PW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
`ifdef SERVO_SEQ_LOOP_EN
      .LOOP(LOOP),
`endif
      .LAST_STEP(LAST_STEP), .WR_EN(WR_EN), .WR_STEP(WR_STEP), .WR_CH(WR_CH),
      .WR_DATA(WR_DATA), .PWM(PWM), .BUSY(BUSY), .DONE(DONE), .STEP(STEP),
      .AT_TARGET(AT_TARGET)
   );

   // ---------------- clock / reset / frame model ----------------
   always #5 CLK = ~CLK;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) fc <= 0;
      else        fc <= (fc == FRAME - 1) ? 0 : fc + 1;
   end

   // Monitor: frame numbering, DONE pulses, STEP changes.
   always @(negedge CLK) begin
      if (!RST_N) begin
         step_prev = '0;
      end else begin
         if (fc == 0) frame_num++;
         if (DONE) begin
            done_cnt++;
            done_frame = frame_num;
            done_fc    = fc;
         end
         if (STEP !== step_prev) begin
            obs_q.push_back({16'(STEP), 16'(frame_num)});
            step_prev = STEP;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_fc(input int v);
      int k = 0;
      while (fc != v && k < 2 * FRAME) begin
         @(negedge CLK);
         k++;
      end
   endtask

   task automatic goto_frame(input int fr, input int pos);
      int k = 0;
      while (!(frame_num == fr && fc == pos) && k < 40 * FRAME) begin
         @(negedge CLK);
         k++;
      end
      check_eq("goto_frame_in_time", 32'(k < 40 * FRAME), 1);
   endtask

   task automatic wr_tbl(input int s, input int ch, input int data);
      WR_EN   = 1'b1;
      WR_STEP = SW'(s);
      WR_CH   = CW'(ch);
      WR_DATA = PW_W'(data);
      @(negedge CLK);
      WR_EN   = 1'b0;
   endtask

   task automatic wr_pose(input int s, input int p0, input int p1, input int p2);
      wr_tbl(s, 0, p0);
      wr_tbl(s, 1, p1);
      wr_tbl(s, 2, p2);
   endtask

   task automatic pulse_start();
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic pulse_abort();
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
   endtask

   // Measures PWM high count over the next full frame; equals each channel's
   // width for that frame (1..FRAME-1).
   task automatic check_frame(input string tag, input int e0, input int e1, input int e2);
      int c0 = 0;
      int c1 = 0;
      int c2 = 0;
      wait_fc(0);
      for (int k = 0; k < FRAME; k++) begin
         if (PWM[0]) c0++;
         if (PWM[1]) c1++;
         if (PWM[2]) c2++;
         @(negedge CLK);
      end
      check_eq({tag, "_ch0"}, c0, e0);
      check_eq({tag, "_ch1"}, c1, e1);
      check_eq({tag, "_ch2"}, c2, e2);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int f1;
      int g1;
      int h1;
      int k1;
      int k2;
      logic [31:0] e;
      logic [31:0] o;

      // Reset values
      @(negedge CLK);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_done", DONE, 0);
      check_eq("rst_step", STEP, 0);
      check_eq("rst_pwm", PWM, 0);
      tick(2);
      RST_N = 1'b1;
      tick(1);
      check_eq("idle_at_target", AT_TARGET, 1);
      check_frame("home", 50, 50, 50);
      check_frame("home2", 50, 50, 50);

      // Single pose, LAST_STEP=0
      wr_pose(0, 80, 50, 20);
      wr_pose(1, 60, 50, 20);
      wr_pose(2, 60, 70, 40);
      LAST_STEP = 3'd0;
      wait_fc(50);
      f1 = frame_num + 1;
      pulse_start();
      check_eq("s0_busy", BUSY, 1);
      check_eq("s0_not_at_target", AT_TARGET, 0);
      check_frame("s0_f1", 60, 50, 40);
      check_frame("s0_f2", 70, 50, 30);
      check_frame("s0_f3", 80, 50, 20);
      goto_frame(f1 + 7, 2);
      check_eq("s0_done_cnt", done_cnt, 1);
      check_eq("s0_done_frame", done_frame, f1 + 7);
      check_eq("s0_done_fc", done_fc, 1);
      check_eq("s0_busy_end", BUSY, 0);
      check_eq("s0_step_end", STEP, 0);

      // Three steps, LAST_STEP=2, with a START while busy
      obs_q.delete();
      LAST_STEP = 3'd2;
      wait_fc(50);
      g1 = frame_num + 1;
      pulse_start();
      exp_q.push_back({16'd1, 16'(g1 + 5)});
      exp_q.push_back({16'd2, 16'(g1 + 12)});
      goto_frame(g1 + 8, 50);
      pulse_start();
      tick(1);
      check_eq("busy_start_step", STEP, 1);
      check_eq("busy_start_busy", BUSY, 1);
      goto_frame(g1 + 12, 50);
      check_frame("s2_f1", 60, 60, 30);
      check_frame("s2_f2", 60, 70, 40);
      goto_frame(g1 + 19, 2);
      check_eq("m_done_cnt", done_cnt, 2);
      check_eq("m_done_frame", done_frame, g1 + 19);
      check_eq("m_busy_end", BUSY, 0);
      check_eq("m_step_held", STEP, 2);
      check_eq("step_log_len", obs_q.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hFFFF_FFFF;
         check_eq("step_log", o, e);
      end

      // ABORT and START together while idle
      wait_fc(50);
      START = 1'b1;
      ABORT = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      ABORT = 1'b0;
      tick(1);
      check_eq("abort_start_busy", BUSY, 0);
      check_eq("abort_start_step", STEP, 2);

      // ABORT mid-MOVE in step 1 at width 70 heading to 80
      wr_pose(0, 60, 70, 40);
      wr_pose(1, 80, 70, 40);
      LAST_STEP = 3'd1;
      wait_fc(50);
      h1 = frame_num + 1;
      pulse_start();
      goto_frame(h1 + 6, 50);
      pulse_abort();
      check_eq("abort_busy", BUSY, 0);
      check_eq("abort_step_held", STEP, 1);
      check_frame("abort_hold1", 70, 70, 40);
      check_frame("abort_hold2", 70, 70, 40);
      check_eq("abort_no_done", done_cnt, 2);

      // Write after abort is accepted; write during BUSY is dropped
      wr_tbl(0, 0, 90);
      LAST_STEP = 3'd0;
      wait_fc(50);
      k1 = frame_num + 1;
      pulse_start();
      wr_tbl(0, 1, 99);
      check_frame("wr_f1", 80, 70, 40);
      check_frame("wr_f2", 90, 70, 40);
      goto_frame(k1 + 6, 2);
      check_eq("wr_done_cnt", done_cnt, 3);
      check_eq("wr_busy_end", BUSY, 0);

      wait_fc(50);
      k2 = frame_num + 1;
      pulse_start();
      check_frame("rerun_f1", 90, 70, 40);
      check_frame("rerun_f2", 90, 70, 40);
      goto_frame(k2 + 5, 2);
      check_eq("rerun_done_cnt", done_cnt, 4);
      check_eq("rerun_done_frame", done_frame, k2 + 5);

`ifdef SERVO_SEQ_LOOP_EN
      begin
         int m1;
         wr_pose(1, 90, 70, 50);
         LAST_STEP = 3'd1;
         LOOP = 1'b1;
         wait_fc(50);
         m1 = frame_num + 1;
         pulse_start();
         LOOP = 1'b0;
         goto_frame(m1 + 11, 2);
         check_eq("loop_done1", done_cnt, 5);
         check_eq("loop_wrap_step", STEP, 0);
         check_eq("loop_busy1", BUSY, 1);
         goto_frame(m1 + 23, 2);
         check_eq("loop_done2", done_cnt, 6);
         check_eq("loop_done2_frame", done_frame, m1 + 23);
         check_eq("loop_busy2", BUSY, 1);
         pulse_abort();
         check_eq("loop_abort_busy", BUSY, 0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
